// File: rtl/i2c_master_ctrl_if.sv
// Controller-side bundle for the I2C bit sequencer: MCU launch controls,
// FIFO handshakes, sampled SDA and the datapath enables.
interface i2c_master_ctrl_if #(
    parameter int LEN_SIZE = 8
);
    logic                start_i;
    logic                rw_i;
    logic [LEN_SIZE-1:0] length_i;
    logic                tx_fifo_empty_i;
    logic                i2c_sda_i;
    logic                sda_low_en_o;
    logic                write_addr_en_o;
    logic                write_data_en_o;
    logic                receive_data_en_o;
    logic [3:0]          count_bit_o;
    logic                sda_oe_o;
    logic                i2c_scl_o;
    logic                tx_fifo_rd_en_o;
    logic                rx_fifo_wr_en_o;
    logic                busy_o;
    logic                done_o;
    logic                nack_o;

    modport master (
        input  start_i, rw_i, length_i, tx_fifo_empty_i, i2c_sda_i,
        output sda_low_en_o, write_addr_en_o, write_data_en_o,
        output receive_data_en_o, count_bit_o, sda_oe_o, i2c_scl_o,
        output tx_fifo_rd_en_o, rx_fifo_wr_en_o, busy_o, done_o, nack_o
    );

    modport slave (
        output start_i, rw_i, length_i, tx_fifo_empty_i, i2c_sda_i,
        input  sda_low_en_o, write_addr_en_o, write_data_en_o,
        input  receive_data_en_o, count_bit_o, sda_oe_o, i2c_scl_o,
        input  tx_fifo_rd_en_o, rx_fifo_wr_en_o, busy_o, done_o, nack_o
    );
endinterface

// File: rtl/i2c_master_ctrl.sv
// I2C master bit sequencer: 4-phase bit timing, START/STOP framing,
// ACK/NACK handling, byte counting and FIFO pop/push strobes.
module i2c_master_ctrl #(
    parameter int DATA_SIZE = 8,
    parameter int ADDR_SIZE = 8,
    parameter int LEN_SIZE  = 8
) (
    input logic               i2c_core_clk_i,
    input logic               reset_ni,
    i2c_master_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WR_DATA,
        WR_ACK, RD_DATA, RD_ACK, STOP
    } state_t;

    localparam logic [3:0] ADDR_TOP = 4'(ADDR_SIZE - 1);
    localparam logic [3:0] DATA_TOP = 4'(DATA_SIZE - 1);
    localparam logic [LEN_SIZE-1:0] ONE = LEN_SIZE'(1);

    state_t              state, state_n;
    logic [1:0]          ph;
    logic [3:0]          count_bit;
    logic [LEN_SIZE-1:0] byte_cnt;
    logic                rw_q;
    logic                sda_q;
    logic                done_q;

    logic       scl, oe, low, wa, wd, rcv;
    logic       rd, wr, nack;
    logic       ld, cdec, bdec, last_ph;
    logic [3:0] ld_val;

    always_ff @(posedge i2c_core_clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state     <= IDLE;
            ph        <= 2'd0;
            count_bit <= 4'd0;
            byte_cnt  <= '0;
            rw_q      <= 1'b0;
            sda_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state  <= state_n;
            ph     <= (state == IDLE) ? 2'd0 : ph + 2'd1;
            done_q <= (state == STOP) && last_ph;
            if (state == IDLE && bus.start_i) begin
                byte_cnt <= bus.length_i;
                rw_q     <= bus.rw_i;
            end else if (bdec) begin
                byte_cnt <= byte_cnt - ONE;
            end
            if (state != IDLE && ph == 2'd2)
                sda_q <= bus.i2c_sda_i;
            if (ld)
                count_bit <= ld_val;
            else if (cdec)
                count_bit <= count_bit - 4'd1;
        end
    end

    always_comb begin
        state_n = state;
        scl     = 1'b1;
        oe      = 1'b0;
        low     = 1'b0;
        wa      = 1'b0;
        wd      = 1'b0;
        rcv     = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        nack    = 1'b0;
        ld      = 1'b0;
        ld_val  = 4'd0;
        cdec    = 1'b0;
        bdec    = 1'b0;
        last_ph = (ph == 2'd3);
        unique case (state)
            IDLE: begin
                if (bus.start_i)
                    state_n = START;
            end
            START: begin
                oe  = 1'b1;
                low = ph[1];
                if (last_ph) begin
                    state_n = ADDR;
                    ld      = 1'b1;
                    ld_val  = ADDR_TOP;
                end
            end
            ADDR: begin
                scl = ph[1];
                oe  = 1'b1;
                wa  = 1'b1;
                if (last_ph) begin
                    if (count_bit == 4'd0)
                        state_n = ADDR_ACK;
                    else
                        cdec = 1'b1;
                end
            end
            ADDR_ACK: begin
                scl = ph[1];
                if (last_ph) begin
                    if (sda_q) begin
                        nack    = 1'b1;
                        state_n = STOP;
                    end else if (byte_cnt == '0) begin
                        state_n = STOP;
                    end else if (rw_q) begin
                        state_n = RD_DATA;
                        ld      = 1'b1;
                        ld_val  = DATA_TOP;
                    end else if (bus.tx_fifo_empty_i) begin
                        state_n = STOP;
                    end else begin
                        state_n = WR_DATA;
                        ld      = 1'b1;
                        ld_val  = DATA_TOP;
                    end
                end
            end
            WR_DATA: begin
                scl = ph[1];
                oe  = 1'b1;
                wd  = 1'b1;
                if (last_ph) begin
                    if (count_bit == 4'd0)
                        state_n = WR_ACK;
                    else
                        cdec = 1'b1;
                end
            end
            WR_ACK: begin
                scl = ph[1];
                if (last_ph) begin
                    if (sda_q) begin
                        nack    = 1'b1;
                        state_n = STOP;
                    end else begin
                        rd   = 1'b1;
                        bdec = 1'b1;
                        // byte just acked was the last one, or nothing queued
                        if (byte_cnt <= ONE || bus.tx_fifo_empty_i) begin
                            state_n = STOP;
                        end else begin
                            state_n = WR_DATA;
                            ld      = 1'b1;
                            ld_val  = DATA_TOP;
                        end
                    end
                end
            end
            RD_DATA: begin
                scl = ph[1];
                rcv = (ph == 2'd2);
                if (last_ph) begin
                    if (count_bit == 4'd0)
                        state_n = RD_ACK;
                    else
                        cdec = 1'b1;
                end
            end
            RD_ACK: begin
                scl = ph[1];
                wr  = (ph == 2'd0);
                // master ACKs every byte except the final one
                if (byte_cnt > ONE) begin
                    oe  = 1'b1;
                    low = 1'b1;
                end
                if (last_ph) begin
                    bdec = 1'b1;
                    if (byte_cnt > ONE) begin
                        state_n = RD_DATA;
                        ld      = 1'b1;
                        ld_val  = DATA_TOP;
                    end else begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                scl = (ph != 2'd0);
                if (!ph[1]) begin
                    oe  = 1'b1;
                    low = 1'b1;
                end
                if (last_ph)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.i2c_scl_o         = scl;
    assign bus.sda_oe_o          = oe;
    assign bus.sda_low_en_o      = low;
    assign bus.write_addr_en_o   = wa;
    assign bus.write_data_en_o   = wd;
    assign bus.receive_data_en_o = rcv;
    assign bus.count_bit_o       = count_bit;
    assign bus.tx_fifo_rd_en_o   = rd;
    assign bus.rx_fifo_wr_en_o   = wr;
    assign bus.nack_o            = nack;
    assign bus.busy_o            = (state != IDLE);
    assign bus.done_o            = done_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for the I2C bit sequencer; cycle index 0 is the
// first START cycle of each transaction.
module tb_i2c_master_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    i2c_master_ctrl_if #(.LEN_SIZE(8)) bus ();

    i2c_master_ctrl #(
        .DATA_SIZE(8),
        .ADDR_SIZE(8),
        .LEN_SIZE (8)
    ) dut (
        .i2c_core_clk_i(clk),
        .reset_ni      (rst_n),
        .bus           (bus.master)
    );

    always #5 clk = ~clk;

    localparam logic [14:0] IDLE_SNAP = 15'h4000;

    int checks   = 0;
    int failures = 0;

    int done_idx, nack_idx, n_rd, n_wr, n_nack, n_done;
    int n_recv, n_addr, n_low, n_excl, n_scl_start;
    logic [31:0] addr_seq;
    logic [14:0] rst_snap;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] snap();
        return {bus.i2c_scl_o, bus.sda_oe_o, bus.sda_low_en_o,
                bus.write_addr_en_o, bus.write_data_en_o,
                bus.receive_data_en_o, bus.count_bit_o,
                bus.tx_fifo_rd_en_o, bus.rx_fifo_wr_en_o,
                bus.busy_o, bus.done_o, bus.nack_o};
    endfunction

    task automatic run_txn(input logic rw, input logic [7:0] len,
                           input logic sda, input int empty_at,
                           input int busy_start_at, input int rst_at);
        int idx;
        int ens;
        done_idx = -1; nack_idx = -1;
        n_rd = 0; n_wr = 0; n_nack = 0; n_done = 0; n_recv = 0;
        n_addr = 0; n_low = 0; n_excl = 0; n_scl_start = 0;
        addr_seq = '0; rst_snap = '0;
        bus.tx_fifo_empty_i = 1'b0;
        bus.i2c_sda_i = sda;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.rw_i     = rw;
        bus.length_i = len;
        @(negedge clk);
        bus.start_i  = 1'b0;
        bus.rw_i     = ~rw;
        bus.length_i = ~len;
        idx = 0;
        while (idx < 400) begin
            if (bus.done_o) begin
                n_done++;
                if (done_idx < 0) done_idx = idx;
            end
            if (bus.nack_o) begin
                n_nack++;
                nack_idx = idx;
            end
            n_rd   += int'(bus.tx_fifo_rd_en_o);
            n_wr   += int'(bus.rx_fifo_wr_en_o);
            n_recv += int'(bus.receive_data_en_o);
            n_low  += int'(bus.sda_low_en_o);
            ens = int'(bus.sda_low_en_o) + int'(bus.write_addr_en_o)
                + int'(bus.write_data_en_o) + int'(bus.receive_data_en_o);
            if (ens > 1) n_excl++;
            if (idx < 4 && bus.i2c_scl_o) n_scl_start++;
            if (bus.write_addr_en_o) begin
                n_addr++;
                if (idx % 4 == 0)
                    addr_seq = {addr_seq[27:0], bus.count_bit_o};
            end
            if (idx == rst_at) begin
                rst_n = 1'b0;
                #1;
                rst_snap = snap();
                repeat (4) begin
                    @(negedge clk);
                    if (bus.done_o || bus.nack_o) n_done++;
                end
                rst_n = 1'b1;
                break;
            end
            if (idx == empty_at) bus.tx_fifo_empty_i = 1'b1;
            bus.start_i = (idx == busy_start_at);
            if (done_idx >= 0 && idx >= done_idx + 3) break;
            @(negedge clk);
            idx++;
        end
        bus.start_i = 1'b0;
        bus.tx_fifo_empty_i = 1'b0;
    endtask

    initial begin
        int nonidle;
        rst_n = 1'b0;
        bus.start_i = 1'b0;
        bus.rw_i = 1'b0;
        bus.length_i = 8'd0;
        bus.tx_fifo_empty_i = 1'b0;
        bus.i2c_sda_i = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_snap", 32'(snap()), 32'(IDLE_SNAP));
        rst_n = 1'b1;
        nonidle = 0;
        repeat (20) begin
            @(negedge clk);
            if (snap() !== IDLE_SNAP) nonidle++;
        end
        check("idle_20_cycles", nonidle, 0);

        // write, 2 bytes, slave ACKs, stray start while busy
        run_txn(1'b0, 8'd2, 1'b0, -1, 20, -1);
        check("wr2_done_idx", done_idx, 116);
        check("wr2_done_cnt", n_done, 1);
        check("wr2_pops", n_rd, 2);
        check("wr2_pushes", n_wr, 0);
        check("wr2_nack", n_nack, 0);
        check("wr2_addr_cycles", n_addr, 32);
        check("wr2_addr_bits", addr_seq, 32'h76543210);
        check("wr2_start_scl", n_scl_start, 4);
        check("wr2_low_cycles", n_low, 4);
        check("wr2_excl", n_excl, 0);
        check("wr2_idle_after", 32'(snap()), 32'(IDLE_SNAP));

        // address NACK
        run_txn(1'b0, 8'd2, 1'b1, -1, -1, -1);
        check("nack_idx", nack_idx, 39);
        check("nack_cnt", n_nack, 1);
        check("nack_pops", n_rd, 0);
        check("nack_done_idx", done_idx, 44);
        check("nack_done_cnt", n_done, 1);

        // read, 3 bytes
        run_txn(1'b1, 8'd3, 1'b0, -1, -1, -1);
        check("rd3_done_idx", done_idx, 152);
        check("rd3_recv", n_recv, 24);
        check("rd3_pushes", n_wr, 3);
        check("rd3_pops", n_rd, 0);
        check("rd3_low_cycles", n_low, 12);
        check("rd3_excl", n_excl, 0);
        check("rd3_idle_after", 32'(snap()), 32'(IDLE_SNAP));

        // write 4 bytes, FIFO runs dry during the second byte
        run_txn(1'b0, 8'd4, 1'b0, 100, -1, -1);
        check("wr4e_pops", n_rd, 2);
        check("wr4e_done_idx", done_idx, 116);
        check("wr4e_done_cnt", n_done, 1);

        // address-only probe
        run_txn(1'b0, 8'd0, 1'b0, -1, -1, -1);
        check("probe_done_idx", done_idx, 44);
        check("probe_pops", n_rd, 0);
        check("probe_nack", n_nack, 0);

        // reset during RD_DATA bit 4, then a clean 1-byte read
        run_txn(1'b1, 8'd3, 1'b0, -1, -1, 54);
        check("rst_mid_snap", 32'(rst_snap), 32'(IDLE_SNAP));
        check("rst_mid_pulses", n_done, 0);
        run_txn(1'b1, 8'd1, 1'b0, -1, -1, -1);
        check("rd1_done_idx", done_idx, 80);
        check("rd1_pushes", n_wr, 1);
        check("rd1_low_cycles", n_low, 4);
        check("rd1_recv", n_recv, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
